// File: rtl/svc_rv_pkg.sv
// Shared register-index definitions for the RV pipeline hazard logic
// (scoreboard, forwarding and hazard units).
package svc_rv_pkg;

  localparam int unsigned NUM_REGS = 32;

  typedef logic [4:0]          reg_idx_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  localparam reg_idx_t REG_X0 = 5'd0;

  // One-hot mask for a register index. x0 is not special-cased here;
  // callers gate x0 themselves.
  function automatic reg_mask_t reg_onehot(input reg_idx_t r);
    reg_mask_t m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/svc_rv_scoreboard.sv
// Tracks registers that have outstanding long-latency writes. ID is stalled
// on RAW/WAW against a pending register, or when the tracker is full.
module svc_rv_scoreboard
  import svc_rv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MAX_PENDING = 4,
  parameter bit          BYPASS_DONE = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [4:0]                         rs1_id,
  input  logic [4:0]                         rs2_id,
  input  logic                               rs1_used_id,
  input  logic                               rs2_used_id,
  input  logic [4:0]                         rd_id,
  input  logic                               reg_write_id,
  input  logic                               long_id,
  input  logic                               issue_id,
  input  logic                               done_valid,
  input  logic [4:0]                         done_rd,
  output logic                               stall_id,
  output logic [31:0]                        pending,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
  output logic                               err_spurious
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

  reg_mask_t         pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  reg_idx_t          rs1, rs2, rd, drd;
  logic              clr_hit, spurious, bypass_hit;
  logic              rs1_hz, rs2_hz, waw, full, stall;
  logic              set_hit;
  reg_mask_t         clr_mask, set_mask;

  always_comb begin
    rs1 = rs1_id;
    rs2 = rs2_id;
    rd  = rd_id;
    drd = done_rd;

    clr_hit    = done_valid && (drd != REG_X0) && pending_q[drd];
    spurious   = done_valid && (drd != REG_X0) && !pending_q[drd];
    // A completion this cycle is already on its way to the regfile, so with
    // bypass enabled it no longer blocks readers or writers of that register.
    bypass_hit = BYPASS_DONE && clr_hit;

    rs1_hz = rs1_used_id && (rs1 != REG_X0) && pending_q[rs1]
             && !(bypass_hit && (drd == rs1));
    rs2_hz = rs2_used_id && (rs2 != REG_X0) && pending_q[rs2]
             && !(bypass_hit && (drd == rs2));
    waw    = reg_write_id && (rd != REG_X0) && pending_q[rd]
             && !(bypass_hit && (drd == rd));
    full   = reg_write_id && long_id && (rd != REG_X0)
             && (cnt_q == CNT_W'(MAX_PENDING)) && !clr_hit;
    stall  = rs1_hz || rs2_hz || waw || full;

    set_hit = issue_id && !stall && reg_write_id && long_id && (rd != REG_X0);

    clr_mask = clr_hit ? reg_onehot(drd) : '0;
    set_mask = set_hit ? reg_onehot(rd)  : '0;

    // Set is applied after clear so a same-cycle complete+reissue keeps the bit.
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;

    cnt_d = cnt_q + CNT_W'(set_hit) - CNT_W'(clr_hit);
    err_d = err_q | spurious;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign stall_id     = stall;
  assign pending      = pending_q;
  assign pending_cnt  = cnt_q;
  assign err_spurious = err_q;

  a_params: assert property (@(posedge clk)
    (MAX_PENDING >= 1) && (MAX_PENDING <= 31) && (XLEN >= 32));

  a_x0_clear: assert property (@(posedge clk) disable iff (!rst_n)
    pending_q[0] == 1'b0);

  a_cnt_popcount: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(pending_q) == int'(cnt_q));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(cnt_q) <= int'(MAX_PENDING));

  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_id && stall));

endmodule

// File: tb/tb_svc_rv_scoreboard.sv
// Self-checking bench for svc_rv_scoreboard: directed scenarios plus a
// randomized run against a set-of-owned-registers reference model.
module tb_svc_rv_scoreboard;

  localparam int unsigned MAXP = 4;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1_id, rs2_id, rd_id, done_rd;
  logic          rs1_used_id, rs2_used_id, reg_write_id, long_id, issue_id, done_valid;
  logic          stall_id;
  logic [31:0]   pending;
  logic [CW-1:0] pending_cnt;
  logic          err_spurious;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: which registers are owned by an in-flight long op.
  bit mp[32];
  bit merr;

  svc_rv_scoreboard #(
    .XLEN        (32),
    .MAX_PENDING (MAXP),
    .BYPASS_DONE (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs1_used_id  (rs1_used_id),
    .rs2_used_id  (rs2_used_id),
    .rd_id        (rd_id),
    .reg_write_id (reg_write_id),
    .long_id      (long_id),
    .issue_id     (issue_id),
    .done_valid   (done_valid),
    .done_rd      (done_rd),
    .stall_id     (stall_id),
    .pending      (pending),
    .pending_cnt  (pending_cnt),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mp[i]);
    return c;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mp[i];
    return v;
  endfunction

  // A completion this cycle hands the register back immediately.
  function automatic bit model_freeing();
    return done_valid && (done_rd != 5'd0) && mp[done_rd];
  endfunction

  function automatic bit model_owned(input logic [4:0] r);
    return (r != 5'd0) && mp[r] && !(model_freeing() && done_rd == r);
  endfunction

  function automatic bit model_stall();
    bit s;
    s = (rs1_used_id && model_owned(rs1_id)) ||
        (rs2_used_id && model_owned(rs2_id)) ||
        (reg_write_id && model_owned(rd_id)) ||
        (reg_write_id && long_id && rd_id != 5'd0 &&
         model_count() == int'(MAXP) && !model_freeing());
    return s;
  endfunction

  task automatic drive(input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit rw, input bit lg, input bit iss,
                       input bit dv, input int drd);
    rs1_id = 5'(r1); rs1_used_id = u1;
    rs2_id = 5'(r2); rs2_used_id = u2;
    rd_id  = 5'(rd); reg_write_id = rw; long_id = lg; issue_id = iss;
    done_valid = dv; done_rd = 5'(drd);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    bit nmp[32];
    bit nerr;
    bit st;
    st   = model_stall();
    nmp  = mp;
    nerr = merr;
    if (done_valid && done_rd != 5'd0) begin
      if (mp[done_rd]) nmp[done_rd] = 1'b0;
      else             nerr = 1'b1;
    end
    if (issue_id && !st && reg_write_id && long_id && rd_id != 5'd0)
      nmp[rd_id] = 1'b1;
    @(posedge clk);
    #1;
    mp   = nmp;
    merr = nerr;
  endtask

  task automatic issue_long(input int rd);
    drive(0, 0, 0, 0, rd, 1, 1, 1, 0, 0);
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      int r;
      r = -1;
      for (int i = 1; i < 32; i++) if (mp[i] && r < 0) r = i;
      if (r < 0) break;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, r);
      tick();
    end
    idle();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mp[i] = 1'b0;
    merr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL reset_pending: got %h want %h", pending, 32'h0); end
    n_cmp++; if (pending_cnt !== CW'(0)) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_spurious); end
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_id); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw_bypass();
    issue_long(5);
    drive(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL raw_stall: got %b want 1", stall_id); end
    drive(5, 1, 0, 0, 0, 0, 0, 0, 1, 5);
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL raw_bypass_release: got %b want 0", stall_id); end
    tick();
    idle();
    n_cmp++; if (pending[5] !== 1'b0) begin n_bad++; $display("FAIL raw_cleared: got %b want 0", pending[5]); end
    n_cmp++; if (pending_cnt !== CW'(0)) begin n_bad++; $display("FAIL raw_cnt: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_x0();
    issue_long(0);
    idle();
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL x0_pending: got %h want 0", pending); end
    n_cmp++; if (pending_cnt !== CW'(0)) begin n_bad++; $display("FAIL x0_cnt: got %0d want 0", pending_cnt); end
    issue_long(3);
    drive(0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL x0_no_stall: got %b want 0", stall_id); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL x0_done_silent: got %b want 0", err_spurious); end
    drain();
  endtask

  task automatic test_full();
    drain();
    for (int r = 1; r <= 4; r++) issue_long(r);
    idle();
    n_cmp++; if (pending_cnt !== CW'(4)) begin n_bad++; $display("FAIL full_cnt: got %0d want 4", pending_cnt); end
    n_cmp++; if (pending !== 32'h0000_001E) begin n_bad++; $display("FAIL full_vec: got %h want %h", pending, 32'h1E); end
    drive(0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL full_stall: got %b want 1", stall_id); end
    drive(0, 0, 0, 0, 6, 1, 1, 1, 1, 2);
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL full_release: got %b want 0", stall_id); end
    tick();
    idle();
    n_cmp++; if (pending_cnt !== CW'(4)) begin n_bad++; $display("FAIL full_cnt_after: got %0d want 4", pending_cnt); end
    n_cmp++; if (pending !== 32'h0000_005A) begin n_bad++; $display("FAIL full_vec_after: got %h want %h", pending, 32'h5A); end
  endtask

  task automatic test_set_clr_same();
    drain();
    issue_long(7);
    drive(0, 0, 0, 0, 7, 1, 1, 1, 1, 7);
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL same_stall: got %b want 0", stall_id); end
    tick();
    idle();
    n_cmp++; if (pending !== 32'h0000_0080) begin n_bad++; $display("FAIL same_vec: got %h want %h", pending, 32'h80); end
    n_cmp++; if (pending_cnt !== CW'(1)) begin n_bad++; $display("FAIL same_cnt: got %0d want 1", pending_cnt); end
  endtask

  task automatic test_waw();
    drain();
    issue_long(9);
    drive(0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL waw_stall: got %b want 1", stall_id); end
    drive(0, 0, 0, 0, 9, 1, 0, 1, 1, 9);
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL waw_release: got %b want 0", stall_id); end
    tick();
    idle();
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL waw_vec: got %h want 0", pending); end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 600; c++) begin
      int lst[$];
      int dsel, dreg;
      bit dv, st;
      for (int i = 1; i < 32; i++) if (mp[i]) lst.push_back(i);
      dsel = int'($urandom_range(0, 19));
      dv   = 1'b0;
      dreg = 0;
      if (dsel < 8 && lst.size() > 0) begin
        dv   = 1'b1;
        dreg = lst[$urandom_range(0, lst.size() - 1)];
      end else if (dsel == 19) begin
        dv = 1'b1;
      end
      drive(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 9)), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0,
            dv, dreg);
      st = model_stall();
      issue_id = !st && 1'($urandom);
      #1;
      n_cmp++; if (stall_id !== st) begin n_bad++; $display("FAIL rand_stall c=%0d: got %b want %b", c, stall_id, st); end
      tick();
      n_cmp++; if (pending !== model_vec()) begin n_bad++; $display("FAIL rand_vec c=%0d: got %h want %h", c, pending, model_vec()); end
      n_cmp++; if (pending_cnt !== CW'(model_count())) begin n_bad++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, pending_cnt, model_count()); end
      n_cmp++; if (err_spurious !== merr) begin n_bad++; $display("FAIL rand_err c=%0d: got %b want %b", c, err_spurious, merr); end
    end
    idle();
  endtask

  task automatic test_spurious_and_reset();
    drain();
    issue_long(1);
    issue_long(2);
    issue_long(5);
    idle();
    n_cmp++; if (pending !== 32'h0000_0026) begin n_bad++; $display("FAIL sp_vec: got %h want %h", pending, 32'h26); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    tick();
    idle();
    n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL sp_err_set: got %b want 1", err_spurious); end
    n_cmp++; if (pending !== 32'h0000_0026) begin n_bad++; $display("FAIL sp_vec_kept: got %h want %h", pending, 32'h26); end
    tick();
    tick();
    n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL sp_err_sticky: got %b want 1", err_spurious); end
    drive(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL sp_pre_rst_stall: got %b want 1", stall_id); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL arst_vec: got %h want 0", pending); end
    n_cmp++; if (pending_cnt !== CW'(0)) begin n_bad++; $display("FAIL arst_cnt: got %0d want 0", pending_cnt); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b want 0", err_spurious); end
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL arst_stall: got %b want 0", stall_id); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_raw_bypass();
    test_x0();
    test_full();
    test_set_clr_same();
    test_waw();
    test_random();
    test_spurious_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
